// File: rtl/nx_fifo_rd_pkg.sv
// nx_fifo_rd_pkg: shared FSM state type for the nx_fifo read-side stream engine
package nx_fifo_rd_pkg;
  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_FLUSH, RD_DONE} rd_state_e;
endpackage

// File: rtl/nx_skid2.sv
// nx_skid2: two-entry registered skid buffer with push/pop/clear, occupancy and head word
module nx_skid2 #(
  parameter int WIDTH = 106,
  parameter int DATA_RESET = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] d0, d1;
  assign head = d0;
  always_ff @(posedge clk)
    if (!rst_n || clear) occ <= '0;
    else occ <= occ + 2'(push) - 2'(pop);
  always_ff @(posedge clk)
    if (!rst_n && DATA_RESET != 0) begin
      d0 <= '0;
      d1 <= '0;
    end else begin
      if (pop && occ == 2'd2) d0 <= d1;
      else if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) d0 <= push_data;
      if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) d1 <= push_data;
    end
endmodule

// File: rtl/nx_fifo_rd_stream.sv
// nx_fifo_rd_stream: pops an nx_fifo into a registered valid/ready stream and sequences FIFO flush
module nx_fifo_rd_stream
  import nx_fifo_rd_pkg::*;
#(
  parameter int WIDTH = 106,
  parameter int CNT_WIDTH = 16,
  parameter int DATA_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_ren,
  output logic                 fifo_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] pop_count
);
  rd_state_e state, nxt;
  logic [1:0] occ;
  logic hs, skid_clear;
  assign out_valid = occ != 2'd0;
  assign hs = out_valid && out_ready;
  assign fifo_ren = rst_n && state == RD_RUN && !flush && !fifo_empty && (occ != 2'd2 || out_ready);
  assign skid_clear = (flush && state != RD_DONE) || state == RD_FLUSH;
  always_comb
    nxt = state == RD_FLUSH ? RD_DONE :
          (flush && state != RD_DONE) ? RD_FLUSH :
          enable ? RD_RUN : RD_IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= RD_IDLE;
      fifo_clear <= 1'b0;
      flush_done <= 1'b0;
      pop_count <= '0;
    end else begin
      state <= nxt;
      fifo_clear <= nxt == RD_FLUSH;
      flush_done <= nxt == RD_DONE;
      pop_count <= pop_count + CNT_WIDTH'(hs);
    end
  nx_skid2 #(.WIDTH(WIDTH), .DATA_RESET(DATA_RESET)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .clear(skid_clear),
    .push(fifo_ren),
    .push_data(fifo_rdata),
    .pop(hs),
    .occ(occ),
    .head(out_data)
  );
endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// tb_nx_fifo_rd_stream: directed self-checking bench for nx_fifo_rd_stream with a behavioural FIFO
module tb_nx_fifo_rd_stream;
  import nx_fifo_rd_pkg::*;
  localparam int W = 16;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n, enable, flush, fifo_empty, fifo_ren, fifo_clear, out_valid, out_ready, flush_done;
  logic [W-1:0] fifo_rdata, out_data;
  logic [CW-1:0] pop_count;
  logic [W-1:0] q[$];
  logic r, c;
  int vec = 0;
  int errs = 0;
  int ren_cnt = 0;
  int uflow = 0;
  nx_fifo_rd_stream #(.WIDTH(W), .CNT_WIDTH(CW), .DATA_RESET(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .flush(flush),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren),
    .fifo_clear(fifo_clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush_done(flush_done),
    .pop_count(pop_count)
  );
  always #5 clk = ~clk;
  function automatic void refresh();
    fifo_empty = q.size() == 0;
    fifo_rdata = fifo_empty ? '0 : q[0];
  endfunction
  task automatic push(input logic [W-1:0] d);
    q.push_back(d);
    refresh();
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #4;
    r = fifo_ren;
    c = fifo_clear;
    if (r) ren_cnt++;
    if (r && fifo_empty) uflow++;
    @(posedge clk);
    #1;
    if (c) q.delete();
    else if (r) void'(q.pop_front());
    refresh();
  end
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    refresh();
    tick();
    tick();
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_clear", 128'(fifo_clear), 128'(0));
    chk("rst_done", 128'(flush_done), 128'(0));
    chk("rst_count", 128'(pop_count), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_ren", 128'(fifo_ren), 128'(0));
    rst_n = 1'b1;
    push(16'h1);
    push(16'h2);
    push(16'h3);
    out_ready = 1'b1;
    enable = 1'b1;
    tick();
    chk("t1_ren_first", 128'(fifo_ren), 128'(1));
    chk("t1_valid_lat", 128'(out_valid), 128'(0));
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_valid", 128'(out_valid), 128'(1));
      chk("t1_data", 128'(out_data), 128'(i));
    end
    tick();
    chk("t1_valid_end", 128'(out_valid), 128'(0));
    chk("t1_count", 128'(pop_count), 128'(3));
    chk("t1_ren_empty", 128'(fifo_ren), 128'(0));
    chk("t1_ren_cnt", 128'(ren_cnt), 128'(3));
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(W'(16'h10 + i));
    tick();
    tick();
    tick();
    tick();
    chk("t2_valid", 128'(out_valid), 128'(1));
    chk("t2_hold", 128'(out_data), 128'(16'h10));
    chk("t2_ren_stall", 128'(fifo_ren), 128'(0));
    chk("t2_fifo_left", 128'(q.size()), 128'(2));
    chk("t2_ren_cnt", 128'(ren_cnt), 128'(5));
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t2_data", 128'(out_data), 128'(16'h10 + i));
    end
    tick();
    chk("t2_valid_end", 128'(out_valid), 128'(0));
    chk("t2_count", 128'(pop_count), 128'(7));
    out_ready = 1'b0;
    push(16'h20);
    push(16'h21);
    push(16'h22);
    tick();
    tick();
    chk("t3_head", 128'(out_data), 128'(16'h20));
    flush = 1'b1;
    out_ready = 1'b1;
    chk("t3_ren_flush", 128'(fifo_ren), 128'(0));
    tick();
    flush = 1'b0;
    chk("t3_clear", 128'(fifo_clear), 128'(1));
    chk("t3_valid_f", 128'(out_valid), 128'(0));
    chk("t3_done_early", 128'(flush_done), 128'(0));
    chk("t3_count", 128'(pop_count), 128'(8));
    tick();
    chk("t3_done", 128'(flush_done), 128'(1));
    chk("t3_clear_off", 128'(fifo_clear), 128'(0));
    chk("t3_valid_d", 128'(out_valid), 128'(0));
    chk("t3_fifo_cleared", 128'(q.size()), 128'(0));
    tick();
    chk("t3_done_off", 128'(flush_done), 128'(0));
    chk("t3_state_run", 128'(dut.state), 128'(RD_RUN));
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(W'(16'h30 + i));
    tick();
    tick();
    chk("t4_head", 128'(out_data), 128'(16'h30));
    enable = 1'b0;
    tick();
    chk("t4_state_idle", 128'(dut.state), 128'(RD_IDLE));
    out_ready = 1'b1;
    chk("t4_ren_off", 128'(fifo_ren), 128'(0));
    tick();
    chk("t4_drain", 128'(out_data), 128'(16'h31));
    chk("t4_ren_off2", 128'(fifo_ren), 128'(0));
    tick();
    chk("t4_valid_end", 128'(out_valid), 128'(0));
    chk("t4_count", 128'(pop_count), 128'(10));
    chk("t4_fifo_left", 128'(q.size()), 128'(2));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_clear", 128'(fifo_clear), 128'(1));
    tick();
    chk("t4_done", 128'(flush_done), 128'(1));
    tick();
    chk("t4_back_idle", 128'(dut.state), 128'(RD_IDLE));
    chk("t4_fifo_cleared", 128'(q.size()), 128'(0));
    enable = 1'b1;
    out_ready = 1'b0;
    push(16'h40);
    push(16'h41);
    push(16'h42);
    tick();
    tick();
    tick();
    chk("t6_valid_pre", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    out_ready = 1'b1;
    chk("t6_ren_rst", 128'(fifo_ren), 128'(0));
    tick();
    chk("t6_valid", 128'(out_valid), 128'(0));
    chk("t6_ren", 128'(fifo_ren), 128'(0));
    chk("t6_count", 128'(pop_count), 128'(0));
    chk("t6_state", 128'(dut.state), 128'(RD_IDLE));
    chk("t6_data", 128'(out_data), 128'(0));
    rst_n = 1'b1;
    enable = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk("t6_fifo_cleared", 128'(q.size()), 128'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(W'(16'h50 + i));
    enable = 1'b1;
    tick();
    chk("t5_ren", 128'(fifo_ren), 128'(1));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t5_data", 128'(out_data), 128'(16'h50 + i));
      chk("t5_count", 128'(pop_count), 128'(i));
    end
    tick();
    chk("t5_valid_end", 128'(out_valid), 128'(0));
    chk("t5_wrap", 128'(pop_count), 128'(0));
    chk("no_underflow", 128'(uflow), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
